rv_buffer: RTL

RV_BUFFER -- requirements
Module: rv_buffer

---
 rtl/rv_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rv_buffer.sv
// rv_buffer: ready/valid FIFO buffer with occupancy FSM, one-cycle first-word latency and tx_done pulse.
// Optional feature: define RV_BUFFER_TXCOUNT_EN to enable the 32-bit output-transfer counter on tx_count.
module rv_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       tx_done,
  output logic [$clog2(DEPTH):0]     level,
  output logic [31:0]                tx_count,
  output logic [1:0]                 state_dbg
);

  // Handshake: a push is in_valid && in_ready and a pop is out_valid && out_ready,
  // both taken at the rising clk edge; in_ready and out_valid depend only on flops.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic               tx_done_q, tx_done_d;
  logic               ready_en_q, ready_en_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic push;
  logic pop;

  // ready_en_q keeps in_ready low during reset and raises it one edge after release.
  assign in_ready  = ready_en_q && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[head_q] : '0;
  assign tx_done   = tx_done_q;
  assign level     = count_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tx_done_d  = pop;
    ready_en_d = 1'b1;

    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);

    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          count_d = LVL_W'(1);
          state_d = ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (push && !pop) begin
          count_d = count_q + LVL_W'(1);
          state_d = (count_q == LVL_W'(DEPTH - 1)) ? ST_FULL : ST_PARTIAL;
        end else if (pop && !push) begin
          count_d = count_q - LVL_W'(1);
          state_d = (count_q == LVL_W'(1)) ? ST_EMPTY : ST_PARTIAL;
        end
      end
      ST_FULL: begin
        if (pop) begin
          count_d = count_q - LVL_W'(1);
          state_d = ST_PARTIAL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tx_done_q  <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tx_done_q  <= tx_done_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Payload storage needs no reset: out_data is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= in_data;
  end

`ifdef RV_BUFFER_TXCOUNT_EN
  logic [31:0] tx_count_q, tx_count_d;

  always_comb begin
    tx_count_d = tx_count_q;
    if (pop) tx_count_d = tx_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_count_q <= 32'd0;
    else       tx_count_q <= tx_count_d;
  end

  assign tx_count = tx_count_q;
`else
  assign tx_count = 32'd0;
`endif

endmodule
